// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus definitions for the memory bus arbiter.
//   state_e : arbiter FSM encoding (IDLE=0, ADDR=1, DATA=2)
//   owner_e : which port owns the current bus transaction
//   SZ_*    : bus size encodings (byte/half/word)
package bus_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_arb_slot.sv
// Per-port completion slot: done flag plus returned read data.
//   clk, rst    : clock, async active-high reset
//   req_i       : port request (held until its stall drops)
//   set_i       : transaction for this port completed on the bus
//   capture_i   : latch rdata_i (read completion)
//   clear_i     : pipeline advances this cycle; forget the completion
//   rdata_i     : bus read data
//   stall_o     : request outstanding and not yet completed
//   rdata_o     : registered read data
module arb_slot #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_i,
   input  logic          set_i,
   input  logic          capture_i,
   input  logic          clear_i,
   input  logic [DW-1:0] rdata_i,
   output logic          stall_o,
   output logic [DW-1:0] rdata_o
);

   logic          done_q, done_d;
   logic [DW-1:0] rdata_q, rdata_d;

   // Clear wins: a completion that lands on an advancing cycle belongs to a
   // withdrawn request and must not satisfy the next one.
   always_comb begin
      done_d  = done_q;
      rdata_d = rdata_q;
      if (clear_i)
         done_d = 1'b0;
      else if (set_i)
         done_d = 1'b1;
      if (capture_i)
         rdata_d = rdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   assign stall_o = req_i & ~done_q;
   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-like bus between the fetch port (i_*) and the
// MEM-stage data port (d_*). Data has priority; one transaction in flight.
//   clk, rst                       : clock, async active-high reset
//   i_req/i_addr/i_rdata/i_stall   : instruction fetch port
//   d_req/d_wr/d_size/d_addr/
//   d_wdata/d_rdata/d_stall        : data load/store port
//   stall_all                      : global pipeline stall (low = advance)
//   req/wr/size/addr/wdata         : bus request side
//   addr_ok/data_ok/rdata          : bus slave handshakes and read data
module mem_bus_arbiter
   import bus_defs::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_stall,
   input  logic          d_req,
   input  logic          d_wr,
   input  logic [1:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_stall,
   input  logic          stall_all,
   output logic          req,
   output logic          wr,
   output logic [1:0]    size,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdata,
   input  logic          addr_ok,
   input  logic          data_ok,
   input  logic [DW-1:0] rdata
);

   state_e state_q;
   owner_e owner_q;

   logic complete, i_set, d_set;

   assign complete = (state_q == ST_DATA) & data_ok;
   assign i_set    = complete & (owner_q == OWN_INST);
   assign d_set    = complete & (owner_q == OWN_DATA);

   arb_slot #(.DW(DW)) u_islot (
      .clk       (clk),
      .rst       (rst),
      .req_i     (i_req),
      .set_i     (i_set),
      .capture_i (i_set),
      .clear_i   (~stall_all),
      .rdata_i   (rdata),
      .stall_o   (i_stall),
      .rdata_o   (i_rdata)
   );

   arb_slot #(.DW(DW)) u_dslot (
      .clk       (clk),
      .rst       (rst),
      .req_i     (d_req),
      .set_i     (d_set),
      .capture_i (d_set & ~d_wr),
      .clear_i   (~stall_all),
      .rdata_i   (rdata),
      .stall_o   (d_stall),
      .rdata_o   (d_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_INST;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (d_stall) begin
                  state_q <= ST_ADDR;
                  owner_q <= OWN_DATA;
               end else if (i_stall) begin
                  state_q <= ST_ADDR;
                  owner_q <= OWN_INST;
               end
            end
            ST_ADDR: begin
               if (addr_ok)
                  state_q <= ST_DATA;
            end
            ST_DATA: begin
               // On completion, hand the bus straight to the other port if it
               // is waiting; the finishing port is excluded since its done
               // flag is only being set this edge.
               if (data_ok) begin
                  if (d_stall && owner_q != OWN_DATA) begin
                     state_q <= ST_ADDR;
                     owner_q <= OWN_DATA;
                  end else if (i_stall && owner_q != OWN_INST) begin
                     state_q <= ST_ADDR;
                     owner_q <= OWN_INST;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      req   = 1'b0;
      wr    = 1'b0;
      size  = '0;
      addr  = '0;
      wdata = '0;
      if (state_q == ST_ADDR) begin
         req = 1'b1;
         if (owner_q == OWN_DATA) begin
            wr    = d_wr;
            size  = d_size;
            addr  = d_addr;
            wdata = d_wdata;
         end else begin
            size = SZ_WORD;
            addr = i_addr;
         end
      end
   end

endmodule
